// File: rtl/ysyx_23060203_axi_rd_arb_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_axi_rd_arb_if
//   AXI4 read-channel bundle (AR + R) shared by the core-side masters and the
//   SoC-side slave port of the read arbiter.
//
//   Parameters : ADDR_W (araddr width), DATA_W (rdata width), ID_W (arid/rid)
//   Modports   :
//     master - drives AR fields and rready; receives arready and the R beat
//     slave  - receives AR fields and rready; drives arready and the R beat
// ---------------------------------------------------------------------------
interface ysyx_23060203_axi_rd_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ysyx_23060203_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_axi_rd_arb
//   Two-master to one-slave AXI4 read arbiter (AR + R channels only).
//   M0 is the ICache refill path, M1 the LSU load path. A single transaction
//   is outstanding at a time; bursts pass straight through and R beats are
//   routed back to the granted master with no buffering.
//
//   Ports:
//     clock      - single clock, all state updates on posedge
//     reset      - asynchronous, active-high
//     m0, m1     - core-side masters (slave modport: arbiter answers them)
//     s          - SoC-side read port (master modport: arbiter drives it)
//     proto_err  - sticky flag: s.rlast disagreed with the beat count
//
//   Configuration macro:
//     YSYX_23060203_RD_ARB_RR_EN
//       defined   : round-robin between M0/M1 using a 1-bit preference pointer
//       undefined : fixed priority, M1 (LSU) over M0 (ICache); M0 may starve
//                   under continuous M1 traffic, which is acceptable here
// ---------------------------------------------------------------------------
module ysyx_23060203_axi_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  ysyx_23060203_axi_rd_arb_if.slave         m0,
  ysyx_23060203_axi_rd_arb_if.slave         m1,
  ysyx_23060203_axi_rd_arb_if.master        s,
  output logic                              proto_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic              grant_q,    grant_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              proto_err_q, proto_err_d;
  logic [ADDR_W-1:0] araddr_q,   araddr_d;
  logic [7:0]        arlen_q,    arlen_d;
  logic [2:0]        arsize_q,   arsize_d;
  logic [1:0]        arburst_q,  arburst_d;
  logic [ID_W-1:0]   arid_q,     arid_d;

  logic in_idle, in_ar, in_r;
  logic any_req;
  logic win;          // 0 = M0, 1 = M1
  logic beat;

  assign in_idle = (state_q == S_IDLE);
  assign in_ar   = (state_q == S_AR);
  assign in_r    = (state_q == S_R);
  assign any_req = m0.arvalid | m1.arvalid;

`ifdef YSYX_23060203_RD_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;
  // On a tie the pointer names the preferred master; a lone requester always wins.
  assign win = (m0.arvalid & m1.arvalid) ? rr_ptr_q : m1.arvalid;
`else
  // Fixed priority: the LSU wins whenever it asks.
  assign win = m1.arvalid;
`endif

  // ---------------- AR side ----------------
  // arready is held low while reset is asserted so no handshake is advertised
  // from a state that is being forced.
  assign m0.arready = in_idle & ~reset & m0.arvalid & ~win;
  assign m1.arready = in_idle & ~reset & m1.arvalid &  win;

  assign s.arvalid  = in_ar;
  assign s.araddr   = araddr_q;
  assign s.arlen    = arlen_q;
  assign s.arsize   = arsize_q;
  assign s.arburst  = arburst_q;
  assign s.arid     = arid_q;

  // ---------------- R side (zero-cycle pass-through) ----------------
  assign s.rready   = in_r & (grant_q ? m1.rready : m0.rready);

  assign m0.rvalid  = in_r & ~grant_q & s.rvalid;
  assign m1.rvalid  = in_r &  grant_q & s.rvalid;
  assign m0.rlast   = in_r & ~grant_q & s.rlast;
  assign m1.rlast   = in_r &  grant_q & s.rlast;

  assign m0.rdata   = s.rdata;
  assign m1.rdata   = s.rdata;
  assign m0.rresp   = s.rresp;
  assign m1.rresp   = s.rresp;
  assign m0.rid     = s.rid;
  assign m1.rid     = s.rid;

  assign beat       = s.rvalid & s.rready;
  assign proto_err  = proto_err_q;

  // ---------------- next-state logic ----------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    arid_d      = arid_q;
`ifdef YSYX_23060203_RD_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // The winner's arready is high this cycle, so this is the handshake.
          araddr_d   = win ? m1.araddr  : m0.araddr;
          arlen_d    = win ? m1.arlen   : m0.arlen;
          arsize_d   = win ? m1.arsize  : m0.arsize;
          arburst_d  = win ? m1.arburst : m0.arburst;
          arid_d     = {{(ID_W-1){1'b0}}, win};
          grant_d    = win;
          beat_cnt_d = 8'd0;
`ifdef YSYX_23060203_RD_ARB_RR_EN
          rr_ptr_d   = ~win;
`endif
          state_d    = S_AR;
        end
      end

      S_AR: begin
        if (s.arready) state_d = S_R;
      end

      S_R: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Termination follows s.rlast; a disagreement with arlen is only flagged.
          if (s.rlast != (beat_cnt_q == arlen_q)) proto_err_d = 1'b1;
          if (s.rlast) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- state registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      beat_cnt_q  <= 8'd0;
      proto_err_q <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= 8'd0;
      arsize_q    <= 3'd0;
      arburst_q   <= 2'd0;
      arid_q      <= '0;
`ifdef YSYX_23060203_RD_ARB_RR_EN
      rr_ptr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      arid_q      <= arid_d;
`ifdef YSYX_23060203_RD_ARB_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060203_axi_rd_arb
//   Directed bench for the two-master AXI read arbiter. Short vector tables
//   cover the combinational arbitration and R routing; hand-written sequences
//   cover full transactions, backpressure, early rlast, async reset and
//   fairness. Inputs are driven 1 ns after the rising edge and outputs are
//   sampled before the next rising edge.
// ---------------------------------------------------------------------------
module tb_ysyx_23060203_axi_rd_arb;

`ifdef YSYX_23060203_RD_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic proto_err;

  always #5 clock = ~clock;

  ysyx_23060203_axi_rd_arb_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m0_if ();
  ysyx_23060203_axi_rd_arb_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m1_if ();
  ysyx_23060203_axi_rd_arb_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s_if ();

  ysyx_23060203_axi_rd_arb #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .m0        (m0_if.slave),
    .m1        (m1_if.slave),
    .s         (s_if.master),
    .proto_err (proto_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic m0v, m1v;
    logic exp_m0_ready, exp_m1_ready;
  } arb_vec_t;

  typedef struct {
    logic srv, m0_rdy, m1_rdy;
    logic exp_m0_rv, exp_m1_rv, exp_s_rready;
  } r_vec_t;

  arb_vec_t arb_tbl[4];
  r_vec_t   r_tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic arready_of(input int m);
    return (m == 0) ? m0_if.arready : m1_if.arready;
  endfunction

  function automatic logic rvalid_of(input int m);
    return (m == 0) ? m0_if.rvalid : m1_if.rvalid;
  endfunction

  function automatic logic rlast_of(input int m);
    return (m == 0) ? m0_if.rlast : m1_if.rlast;
  endfunction

  function automatic logic [31:0] rdata_of(input int m);
    return (m == 0) ? m0_if.rdata : m1_if.rdata;
  endfunction

  function automatic logic [1:0] rresp_of(input int m);
    return (m == 0) ? m0_if.rresp : m1_if.rresp;
  endfunction

  task automatic set_req(input int m, input logic v, input logic [31:0] addr, input logic [7:0] len);
    if (m == 0) begin
      m0_if.arvalid = v; m0_if.araddr = addr; m0_if.arlen = len;
      m0_if.arsize = 3'd2; m0_if.arburst = 2'b01;
    end else begin
      m1_if.arvalid = v; m1_if.araddr = addr; m1_if.arlen = len;
      m1_if.arsize = 3'd2; m1_if.arburst = 2'b01;
    end
  endtask

  task automatic set_rready(input int m, input logic v);
    if (m == 0) m0_if.rready = v;
    else        m1_if.rready = v;
  endtask

  // Called in IDLE with requests already driven: expect master exp_m to win now.
  task automatic handshake(input string tag, input int exp_m, input bit clear);
    #1;
    check({tag, " winner arready"}, arready_of(exp_m), 1'b1);
    check({tag, " loser arready"}, arready_of(1 - exp_m), 1'b0);
    check({tag, " s_arvalid in IDLE"}, s_if.arvalid, 1'b0);
    tick();
    if (clear) begin
      if (exp_m == 0) m0_if.arvalid = 1'b0;
      else            m1_if.arvalid = 1'b0;
    end
  endtask

  // Entered one cycle after the AR handshake; leaves the DUT in R.
  task automatic slave_ar(input string tag, input int exp_id, input logic [31:0] exp_addr,
                          input logic [7:0] exp_len, input int stall);
    check({tag, " s_arvalid 1 cycle after handshake"}, s_if.arvalid, 1'b1);
    check({tag, " s_arid"}, s_if.arid, exp_id[3:0]);
    check({tag, " s_araddr"}, s_if.araddr, exp_addr);
    check({tag, " s_arlen"}, s_if.arlen, exp_len);
    check({tag, " arready low in AR"}, m0_if.arready | m1_if.arready, 1'b0);
    for (int k = 0; k < stall; k++) begin
      tick();
      check($sformatf("%s stall%0d s_arvalid", tag, k), s_if.arvalid, 1'b1);
      check($sformatf("%s stall%0d s_araddr", tag, k), s_if.araddr, exp_addr);
      check($sformatf("%s stall%0d s_arlen", tag, k), s_if.arlen, exp_len);
    end
    s_if.arready = 1'b1;
    tick();
    s_if.arready = 1'b0;
  endtask

  // Presents nbeats R beats (rlast on index last_at); optionally stalls the
  // granted master's rready for one cycle on beat hold_at.
  task automatic slave_r(input string tag, input int gm, input int nbeats, input int last_at,
                         input logic [31:0] base, input int hold_at);
    for (int b = 0; b < nbeats; b++) begin
      s_if.rvalid = 1'b1;
      s_if.rdata  = base + b;
      s_if.rlast  = (b == last_at);
      s_if.rresp  = (b == 1) ? 2'b10 : 2'b00;
      if (b == hold_at) begin
        set_rready(gm, 1'b0);
        #1;
        check($sformatf("%s b%0d held s_rready", tag, b), s_if.rready, 1'b0);
        check($sformatf("%s b%0d held rvalid", tag, b), rvalid_of(gm), 1'b1);
        tick();
        set_rready(gm, 1'b1);
      end
      #1;
      check($sformatf("%s b%0d rvalid", tag, b), rvalid_of(gm), 1'b1);
      check($sformatf("%s b%0d other rvalid", tag, b), rvalid_of(1 - gm), 1'b0);
      check($sformatf("%s b%0d rdata", tag, b), rdata_of(gm), base + b);
      check($sformatf("%s b%0d rresp", tag, b), rresp_of(gm), (b == 1) ? 2'b10 : 2'b00);
      check($sformatf("%s b%0d rlast", tag, b), rlast_of(gm), (b == last_at));
      check($sformatf("%s b%0d other rlast", tag, b), rlast_of(1 - gm), 1'b0);
      check($sformatf("%s b%0d s_rready", tag, b), s_if.rready, 1'b1);
      tick();
    end
    s_if.rvalid = 1'b0;
    s_if.rlast  = 1'b0;
    s_if.rresp  = 2'b00;
  endtask

  // A stray slave beat while IDLE must not be accepted nor forwarded.
  task automatic idle_check(input string tag);
    s_if.rvalid = 1'b1;
    #1;
    check({tag, " idle s_rready"}, s_if.rready, 1'b0);
    check({tag, " idle m0_rvalid"}, m0_if.rvalid, 1'b0);
    check({tag, " idle m1_rvalid"}, m1_if.rvalid, 1'b0);
    check({tag, " idle s_arvalid"}, s_if.arvalid, 1'b0);
    s_if.rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int first_m, n_m0, n_m1, exp_m;

    arb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    arb_tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    arb_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    arb_tbl[3] = '{1'b1, 1'b1, RR_EN, ~RR_EN};   // tie: rr_ptr=0 prefers M0; fixed prefers M1

    // Grant held by M0 during these vectors.
    r_tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    r_tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    r_tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    r_tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    set_req(0, 1'b0, 32'h0, 8'd0);
    set_req(1, 1'b0, 32'h0, 8'd0);
    m0_if.arid = 4'd0; m1_if.arid = 4'd0;
    m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = 32'h0;
    s_if.rresp = 2'b00; s_if.rlast = 1'b0; s_if.rid = 4'd0;

    #12;
    check("reset m0_arready", m0_if.arready, 1'b0);
    check("reset m1_arready", m1_if.arready, 1'b0);
    check("reset s_arvalid", s_if.arvalid, 1'b0);
    check("reset s_rready", s_if.rready, 1'b0);
    check("reset m0_rvalid", m0_if.rvalid, 1'b0);
    check("reset proto_err", proto_err, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // ---- IDLE arbitration table (requests withdrawn before the edge) ----
    for (int i = 0; i < 4; i++) begin
      m0_if.arvalid = arb_tbl[i].m0v;
      m1_if.arvalid = arb_tbl[i].m1v;
      #1;
      check($sformatf("arb[%0d] m0_arready", i), m0_if.arready, arb_tbl[i].exp_m0_ready);
      check($sformatf("arb[%0d] m1_arready", i), m1_if.arready, arb_tbl[i].exp_m1_ready);
      m0_if.arvalid = 1'b0;
      m1_if.arvalid = 1'b0;
      #1;
    end
    tick();

    // ---- Simultaneous requests ----
    first_m = RR_EN ? 0 : 1;
    set_req(0, 1'b1, 32'h8000_0100, 8'd0);
    set_req(1, 1'b1, 32'h9000_0000, 8'd1);
    handshake("tie first", first_m, 1'b1);
    if (first_m == 1) begin
      slave_ar("tie first", 1, 32'h9000_0000, 8'd1, 0);
      slave_r("tie first", 1, 2, 1, 32'hA000_0000, -1);
    end else begin
      slave_ar("tie first", 0, 32'h8000_0100, 8'd0, 0);
      slave_r("tie first", 0, 1, 0, 32'hA000_0000, -1);
    end
    handshake("tie second", 1 - first_m, 1'b1);
    if (first_m == 1) begin
      slave_ar("tie second", 0, 32'h8000_0100, 8'd0, 0);
      slave_r("tie second", 0, 1, 0, 32'hA100_0000, -1);
    end else begin
      slave_ar("tie second", 1, 32'h9000_0000, 8'd1, 0);
      slave_r("tie second", 1, 2, 1, 32'hA100_0000, -1);
    end

    // ---- M0 alone, 4-beat burst, with R routing table ----
    set_req(0, 1'b1, 32'h8000_0000, 8'd3);
    handshake("m0 burst", 0, 1'b1);
    slave_ar("m0 burst", 0, 32'h8000_0000, 8'd3, 0);
    for (int i = 0; i < 4; i++) begin
      s_if.rvalid  = r_tbl[i].srv;
      m0_if.rready = r_tbl[i].m0_rdy;
      m1_if.rready = r_tbl[i].m1_rdy;
      #1;
      check($sformatf("rt[%0d] m0_rvalid", i), m0_if.rvalid, r_tbl[i].exp_m0_rv);
      check($sformatf("rt[%0d] m1_rvalid", i), m1_if.rvalid, r_tbl[i].exp_m1_rv);
      check($sformatf("rt[%0d] s_rready", i), s_if.rready, r_tbl[i].exp_s_rready);
    end
    s_if.rvalid = 1'b0; m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    slave_r("m0 burst", 0, 4, 3, 32'hB000_0000, -1);
    idle_check("m0 burst");
    check("m0 burst proto_err", proto_err, 1'b0);

    // ---- Backpressure on AR and R ----
    set_req(0, 1'b1, 32'h8000_0200, 8'd3);
    handshake("bp", 0, 1'b1);
    slave_ar("bp", 0, 32'h8000_0200, 8'd3, 5);
    slave_r("bp", 0, 4, 3, 32'hC000_0000, 1);
    idle_check("bp");
    check("bp proto_err", proto_err, 1'b0);

    // ---- Early rlast, then a clean transaction ----
    set_req(0, 1'b1, 32'h8000_0300, 8'd3);
    handshake("early", 0, 1'b1);
    slave_ar("early", 0, 32'h8000_0300, 8'd3, 0);
    slave_r("early", 0, 2, 1, 32'hD000_0000, -1);
    check("early proto_err set", proto_err, 1'b1);
    idle_check("early");
    set_req(1, 1'b1, 32'h9000_0300, 8'd0);
    handshake("clean", 1, 1'b1);
    slave_ar("clean", 1, 32'h9000_0300, 8'd0, 0);
    slave_r("clean", 1, 1, 0, 32'hD100_0000, -1);
    check("clean proto_err sticky", proto_err, 1'b1);

    // ---- Async reset in the middle of a burst ----
    set_req(0, 1'b1, 32'h8000_0400, 8'd3);
    handshake("rst", 0, 1'b1);
    slave_ar("rst", 0, 32'h8000_0400, 8'd3, 0);
    s_if.rvalid = 1'b1; s_if.rdata = 32'hE000_0000; s_if.rlast = 1'b0;
    #1;
    check("rst beat0 m0_rvalid", m0_if.rvalid, 1'b1);
    tick();
    s_if.rdata = 32'hE000_0001;
    set_req(1, 1'b1, 32'h9000_0400, 8'd1);
    #1;
    check("rst beat1 m0_rvalid", m0_if.rvalid, 1'b1);
    reset = 1'b1;
    #1;
    check("rst m0_rvalid", m0_if.rvalid, 1'b0);
    check("rst m1_rvalid", m1_if.rvalid, 1'b0);
    check("rst s_rready", s_if.rready, 1'b0);
    check("rst s_arvalid", s_if.arvalid, 1'b0);
    check("rst m1_arready", m1_if.arready, 1'b0);
    check("rst proto_err", proto_err, 1'b0);
    s_if.rvalid = 1'b0;
    set_req(1, 1'b0, 32'h9000_0400, 8'd1);
    tick();
    @(negedge clock);
    reset = 1'b0;
    tick();
    idle_check("post rst");
    set_req(1, 1'b1, 32'h9000_0400, 8'd1);
    handshake("post rst", 1, 1'b1);
    slave_ar("post rst", 1, 32'h9000_0400, 8'd1, 0);
    slave_r("post rst", 1, 2, 1, 32'hF000_0000, -1);
    check("post rst proto_err", proto_err, 1'b0);

    // ---- Continuous requests from both masters ----
    // Last grant was M1, so round-robin prefers M0 next; fixed priority keeps M1.
    n_m0 = 0;
    n_m1 = 0;
    set_req(0, 1'b1, 32'h8000_0500, 8'd0);
    set_req(1, 1'b1, 32'h9000_0500, 8'd0);
    for (int t = 0; t < (RR_EN ? 10 : 3); t++) begin
      exp_m = RR_EN ? (t % 2) : 1;
      handshake($sformatf("cont%0d", t), exp_m, 1'b0);
      if (s_if.arid == 4'd0) n_m0++;
      else                   n_m1++;
      slave_ar($sformatf("cont%0d", t), exp_m,
               (exp_m == 0) ? 32'h8000_0500 : 32'h9000_0500, 8'd0, 0);
      slave_r($sformatf("cont%0d", t), exp_m, 1, 0, 32'h1000_0000 + t, -1);
    end
    set_req(0, 1'b0, 32'h0, 8'd0);
    set_req(1, 1'b0, 32'h0, 8'd0);
    check("cont m0 grants", n_m0, RR_EN ? 5 : 0);
    check("cont m1 grants", n_m1, RR_EN ? 5 : 3);
    idle_check("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
